carrier_hop_sched: RTL and testbench

- Frequency-hop / sweep scheduler that drives the 16-bit `freq` input of the I/Q carrier generator.
- Holds a small table of (frequency, dwell) entries written by the configuration side.
- On start, steps through the table. Frequency changes only on symbol boundaries (`sym_tick`), so a carrier hop never lands mid-symbol.
- Sits between the control/config logic and the carrier generator, in the carrier clock domain (230,401.25 Hz).

---
 rtl/carrier_hop_sched_if.sv | 34 +++
 rtl/carrier_hop_sched.sv | 187 ++++++++++++++++++
 tb/tb_carrier_hop_sched.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/carrier_hop_sched_if.sv
// Config/control and carrier-side bundle for carrier_hop_sched.
// master = config/control side, slave = the scheduler itself.
interface carrier_hop_sched_if #(
  parameter int AW      = 3,
  parameter int DWELL_W = 16
);
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [15:0]        cfg_freq;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [AW:0]        cfg_num;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               sym_tick;
  logic [15:0]        freq;
  logic               freq_upd;
  logic [AW-1:0]      entry_idx;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_freq, cfg_dwell, cfg_num, loop_en,
           start, stop, sym_tick,
    input  freq, freq_upd, entry_idx, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_freq, cfg_dwell, cfg_num, loop_en,
           start, stop, sym_tick,
    output freq, freq_upd, entry_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/carrier_hop_sched.sv
// Frequency-hop scheduler: walks a (freq, dwell) table and retunes the
// carrier only on symbol boundaries so no hop lands mid-symbol.
module carrier_hop_sched #(
  parameter int          DEPTH    = 8,
  parameter int          AW       = 3,
  parameter int          DWELL_W  = 16,
  parameter logic [15:0] FREQ_MAX = 16'd65065
) (
  input  logic                clk,
  input  logic                rst,
  carrier_hop_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ALIGN = 2'd1,
    DWELL      = 2'd2
  } state_t;

  localparam logic [AW:0]      DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [DWELL_W-1:0] ONE_D = DWELL_W'(1);

  state_t             state_reg, state_next;
  logic [15:0]        freq_reg, freq_next;
  logic               freq_upd_reg, freq_upd_next;
  logic [AW-1:0]      entry_idx_reg, entry_idx_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               cfg_err_reg, cfg_err_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]      idx_reg, idx_next;
  logic [AW:0]        num_reg, num_next;
  logic               loop_reg, loop_next;

  logic [15:0]        freq_tab  [DEPTH];
  logic [DWELL_W-1:0] dwell_tab [DEPTH];

  logic               tab_we;
  logic [15:0]        wr_freq;
  logic               wr_clamp;
  logic               num_ok;
  logic               last_entry;
  logic [AW-1:0]      idx_inc;

  // Writes are only accepted while idle so a running sweep sees a frozen table.
  assign tab_we   = bus.cfg_we && (state_reg == IDLE);
  assign wr_clamp = bus.cfg_freq > FREQ_MAX;
  assign wr_freq  = wr_clamp ? FREQ_MAX : bus.cfg_freq;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          freq_tab[gi]  <= '0;
          dwell_tab[gi] <= '0;
        end else if (tab_we && (bus.cfg_addr == AW'(gi))) begin
          freq_tab[gi]  <= wr_freq;
          dwell_tab[gi] <= bus.cfg_dwell;
        end
      end
    end
  endgenerate

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? ONE_D : d;
  endfunction

  assign num_ok     = (bus.cfg_num != '0) && (bus.cfg_num <= DEPTH_L);
  assign last_entry = ({1'b0, idx_reg} == (num_reg - 1'b1));
  assign idx_inc    = idx_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    freq_next      = freq_reg;
    freq_upd_next  = 1'b0;
    entry_idx_next = entry_idx_reg;
    done_next      = 1'b0;
    cfg_err_next   = 1'b0;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    num_next       = num_reg;
    loop_next      = loop_reg;

    if (bus.cfg_we) begin
      cfg_err_next = (state_reg != IDLE) || wr_clamp;
    end

    if (bus.stop) begin
      // Abort wins over start and sym_tick; outputs keep their last value.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (num_ok) begin
              num_next   = bus.cfg_num;
              loop_next  = bus.loop_en;
              idx_next   = '0;
              state_next = WAIT_ALIGN;
            end else begin
              cfg_err_next = 1'b1;
            end
          end
        end

        WAIT_ALIGN: begin
          if (bus.sym_tick) begin
            freq_next      = freq_tab[0];
            entry_idx_next = '0;
            idx_next       = '0;
            freq_upd_next  = 1'b1;
            cnt_next       = eff_dwell(dwell_tab[0]);
            state_next     = DWELL;
          end
        end

        DWELL: begin
          if (bus.sym_tick) begin
            if (cnt_reg > ONE_D) begin
              cnt_next = cnt_reg - ONE_D;
            end else if (!last_entry) begin
              idx_next       = idx_inc;
              entry_idx_next = idx_inc;
              freq_next      = freq_tab[idx_inc];
              cnt_next       = eff_dwell(dwell_tab[idx_inc]);
              freq_upd_next  = 1'b1;
            end else if (loop_reg) begin
              // Wrap straight to entry 0 on this boundary, no realignment gap.
              idx_next       = '0;
              entry_idx_next = '0;
              freq_next      = freq_tab[0];
              cnt_next       = eff_dwell(dwell_tab[0]);
              freq_upd_next  = 1'b1;
            end else begin
              done_next  = 1'b1;
              cnt_next   = '0;
              state_next = IDLE;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      freq_reg      <= '0;
      freq_upd_reg  <= 1'b0;
      entry_idx_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      num_reg       <= '0;
      loop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      freq_reg      <= freq_next;
      freq_upd_reg  <= freq_upd_next;
      entry_idx_reg <= entry_idx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      cfg_err_reg   <= cfg_err_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      num_reg       <= num_next;
      loop_reg      <= loop_next;
    end
  end

  assign bus.freq      = freq_reg;
  assign bus.freq_upd  = freq_upd_reg;
  assign bus.entry_idx = entry_idx_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_carrier_hop_sched.sv
// Self-checking bench for carrier_hop_sched: vector-driven table writes,
// a reference sweep model, and a scoreboard of expected frequency updates.
module tb_carrier_hop_sched;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int FMAX  = 65065;

  logic clk;
  logic rst;

  carrier_hop_sched_if #(.AW(AW), .DWELL_W(DW)) bus ();

  carrier_hop_sched #(
    .DEPTH(DEPTH), .AW(AW), .DWELL_W(DW), .FREQ_MAX(16'd65065)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int f_in;
    int dwell;
    int f_store;
    int err;
  } wr_vec_t;

  typedef struct {
    int f;
    int i;
  } upd_t;

  upd_t sb_q[$];

  // Reference model state
  bit m_run, m_wait, m_loop;
  int m_idx, m_cnt, m_num, m_freq;
  int m_tab_f [DEPTH];
  int m_tab_d [DEPTH];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard: every freq_upd pulse must match the oldest expected update.
  always @(negedge clk) begin
    if (!rst && bus.freq_upd) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_upd", 1, 0);
      end else begin
        upd_t e;
        e = sb_q.pop_front();
        chk("sb_freq", int'(bus.freq), e.f);
        chk("sb_idx", int'(bus.entry_idx), e.i);
        $display("upd freq=%0d idx=%0d", bus.freq, bus.entry_idx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_load();
    upd_t u;
    m_freq = m_tab_f[m_idx];
    m_cnt  = (m_tab_d[m_idx] == 0) ? 1 : m_tab_d[m_idx];
    u.f = m_freq;
    u.i = m_idx;
    sb_q.push_back(u);
  endtask

  task automatic do_write(input int addr, input int f, input int d,
                          input int f_store, input int exp_err);
    @(posedge clk); #1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = AW'(addr);
    bus.cfg_freq  = 16'(f);
    bus.cfg_dwell = DW'(d);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (!m_run) begin
      m_tab_f[addr] = f_store;
      m_tab_d[addr] = d;
    end
    chk("wr_cfg_err", int'(bus.cfg_err), exp_err);
    $display("write addr=%0d freq=%0d dwell=%0d cfg_err=%0d", addr, f, d, bus.cfg_err);
  endtask

  task automatic do_start(input int num, input bit lp, input bit with_stop);
    int exp_err;
    exp_err = 0;
    @(posedge clk); #1;
    bus.cfg_num = (AW+1)'(num);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    bus.stop    = with_stop;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (with_stop) begin
      m_run = 0;
    end else if (!m_run) begin
      if (num >= 1 && num <= DEPTH) begin
        m_run = 1; m_wait = 1; m_num = num; m_loop = lp; m_idx = 0;
      end else begin
        exp_err = 1;
      end
    end
    chk("start_cfg_err", int'(bus.cfg_err), exp_err);
    chk("start_busy", int'(bus.busy), int'(m_run));
    $display("start num=%0d loop=%0d stop=%0d busy=%0d cfg_err=%0d",
             num, lp, with_stop, bus.busy, bus.cfg_err);
  endtask

  task automatic do_tick(input bit with_stop);
    bit e_upd, e_done;
    e_upd = 0; e_done = 0;
    if (with_stop) begin
      m_run = 0;
    end else if (m_run) begin
      if (m_wait) begin
        m_wait = 0; m_idx = 0; model_load(); e_upd = 1;
      end else if (m_cnt > 1) begin
        m_cnt--;
      end else if (m_idx < m_num - 1) begin
        m_idx++; model_load(); e_upd = 1;
      end else if (m_loop) begin
        m_idx = 0; model_load(); e_upd = 1;
      end else begin
        e_done = 1; m_run = 0;
      end
    end
    @(posedge clk); #1;
    bus.sym_tick = 1'b1;
    bus.stop     = with_stop;
    @(posedge clk); #1;
    bus.sym_tick = 1'b0;
    bus.stop     = 1'b0;
    chk("tick_freq_upd", int'(bus.freq_upd), int'(e_upd));
    chk("tick_done", int'(bus.done), int'(e_done));
    chk("tick_freq", int'(bus.freq), m_freq);
    chk("tick_busy", int'(bus.busy), int'(m_run));
    $display("tick stop=%0d freq=%0d upd=%0d done=%0d busy=%0d",
             with_stop, bus.freq, bus.freq_upd, bus.done, bus.busy);
    repeat (8) @(posedge clk);
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    m_run = 0;
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_freq_hold", int'(bus.freq), m_freq);
    $display("stop busy=%0d freq=%0d", bus.busy, bus.freq);
  endtask

  wr_vec_t vecs [6];

  initial begin
    vecs[0] = '{addr: 0, f_in: 1000,  dwell: 2, f_store: 1000,  err: 0};
    vecs[1] = '{addr: 1, f_in: 20000, dwell: 1, f_store: 20000, err: 0};
    vecs[2] = '{addr: 2, f_in: 65065, dwell: 3, f_store: 65065, err: 0};
    vecs[3] = '{addr: 5, f_in: 65066, dwell: 4, f_store: FMAX,  err: 1};
    vecs[4] = '{addr: 6, f_in: 65535, dwell: 0, f_store: FMAX,  err: 1};
    vecs[5] = '{addr: 7, f_in: 0,     dwell: 9, f_store: 0,     err: 0};

    m_run = 0; m_wait = 0; m_loop = 0;
    m_idx = 0; m_cnt = 0; m_num = 0; m_freq = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_tab_f[i] = 0;
      m_tab_d[i] = 0;
    end

    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_freq = '0; bus.cfg_dwell = '0;
    bus.cfg_num = '0; bus.loop_en = 0; bus.start = 0; bus.stop = 0;
    bus.sym_tick = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freq", int'(bus.freq), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_idx", int'(bus.entry_idx), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_cfg_err", int'(bus.cfg_err), 0);
    rst = 1'b0;

    // Table writes from the vector list, including clamped frequencies.
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].f_in, vecs[i].dwell, vecs[i].f_store, vecs[i].err);
    end

    // Three-entry non-loop sweep: done lands on the 7th tick.
    do_start(3, 0, 0);
    for (int t = 0; t < 7; t++) do_tick(0);
    repeat (5) @(posedge clk);
    #1;
    chk("sweep_hold_freq", int'(bus.freq), 65065);
    chk("sweep_hold_idx", int'(bus.entry_idx), 2);

    // Loop wrap across two entries.
    do_write(0, 5000, 1, 5000, 0);
    do_write(1, 6000, 1, 6000, 0);
    do_start(2, 1, 0);
    for (int t = 0; t < 7; t++) do_tick(0);
    do_stop();

    // Clamp readback plus dwell-zero entry lasting exactly one tick.
    do_write(0, 65535, 0, FMAX, 1);
    do_write(1, 7000, 2, 7000, 0);
    do_start(2, 0, 0);
    for (int t = 0; t < 4; t++) do_tick(0);

    // Illegal entry counts.
    do_start(0, 0, 0);
    do_start(9, 1, 0);

    // Write while busy is rejected; start while busy is silently ignored.
    do_write(0, 3000, 2, 3000, 0);
    do_start(1, 1, 0);
    do_write(0, 9999, 1, 9999, 1);
    do_start(3, 0, 0);
    for (int t = 0; t < 4; t++) do_tick(0);
    do_tick(1);
    chk("stop_tick_idx", int'(bus.entry_idx), 0);

    // start together with stop in IDLE.
    do_start(2, 0, 1);

    // Asynchronous reset mid-dwell takes effect before the next edge.
    do_start(1, 0, 0);
    do_tick(0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_freq", int'(bus.freq), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_idx", int'(bus.entry_idx), 0);
    $display("async reset freq=%0d busy=%0d idx=%0d", bus.freq, bus.busy, bus.entry_idx);
    m_run = 0; m_freq = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_tab_f[i] = 0;
      m_tab_d[i] = 0;
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Table was cleared by reset: a run now outputs frequency 0.
    do_write(1, 4000, 1, 4000, 0);
    do_start(2, 0, 0);
    for (int t = 0; t < 3; t++) do_tick(0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
